// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer_a controller: command encoding and FSM state type.
package buffer_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SEND  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CMD  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_SEND_CMD  = 3'd3,
    ST_SEND_WAIT = 3'd4,
    ST_SEND_DATA = 3'd5,
    ST_CLEAR     = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/buffer_ctrl_beat_counter.sv
// Loadable down-counter shared by every phase of buffer_ctrl.
// last is high while the count sits on its final step (value 1).
module beat_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero so a stray enable cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: sequences LOAD / SEND / CLEAR operations towards buffer_a.
// Optional feature: define BUFFER_CTRL_VALID_EN to track per-buffer content
// valid bits and reject SEND to a buffer that holds no loaded data.
//
// state        | meaning
// -------------+-------------------------------------------------
// ST_IDLE      | ready for a request; invalid requests pulse err
// ST_LOAD_CMD  | cmd=LOAD for one cycle
// ST_LOAD_DATA | stream dim_x*dim_y elements from in_* to a_out
// ST_SEND_CMD  | cmd=SEND for one cycle
// ST_SEND_WAIT | one cycle of buffer read latency
// ST_SEND_DATA | qualify dim_x columns with out_valid/out_ready
// ST_CLEAR     | cmd=CLEAR held for MMU_SIZE cycles
// ST_DONE      | done pulse, back to IDLE
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int VAR_SIZE = 8,
  parameter int MMU_SIZE = 10,
  parameter int BUF_NUM  = 10,
  parameter int DIM_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [4:0]          req_buf,
  input  logic [DIM_W-1:0]    req_dim_x,
  input  logic [DIM_W-1:0]    req_dim_y,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VAR_SIZE-1:0] in_data,
  output logic [VAR_SIZE-1:0] a_out,
  output logic [1:0]          cmd,
  output logic [4:0]          buffer,
  output logic [DIM_W-1:0]    dim_x,
  output logic [DIM_W-1:0]    dim_y,
  output logic                stop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int               CNT_W   = $clog2(MMU_SIZE * MMU_SIZE + 1);
  localparam logic [4:0]       BUF_LIM = 5'(BUF_NUM);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MMU_SIZE);
  localparam logic [CNT_W-1:0] CLR_LEN = CNT_W'(MMU_SIZE);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       buf_q, buf_d;
  logic [DIM_W-1:0] dim_x_q, dim_x_d, dim_y_q, dim_y_d;
  logic             err_q, err_d;
  logic             cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt_val;
  logic             req_ok, buf_has_data;

`ifdef BUFFER_CTRL_VALID_EN
  logic [BUF_NUM-1:0] valid_q, valid_d;

  // Look up the content flag of the requested buffer.
  always_comb begin
    buf_has_data = 1'b0;
    for (int i = 0; i < BUF_NUM; i++) begin
      if (req_buf == 5'(i)) buf_has_data = valid_q[i];
    end
  end

  // A completed LOAD marks its buffer filled, a completed CLEAR empties it.
  always_comb begin
    valid_d = valid_q;
    if (state_q == ST_DONE) begin
      for (int i = 0; i < BUF_NUM; i++) begin
        if (buf_q == 5'(i)) begin
          if (op_q == CMD_LOAD)       valid_d[i] = 1'b1;
          else if (op_q == CMD_CLEAR) valid_d[i] = 1'b0;
        end
      end
    end
  end

  // Valid bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end
`else
  assign buf_has_data = 1'b1;
`endif

  assign req_ok = (req_op != CMD_NONE) && (req_buf < BUF_LIM) &&
                  (req_dim_x != '0) && (req_dim_x <= DIM_MAX) &&
                  (req_dim_y != '0) && (req_dim_y <= DIM_MAX) &&
                  ((req_op != CMD_SEND) || buf_has_data);

  // Phase length loaded at accept: elements for LOAD, columns for SEND, hold for CLEAR.
  always_comb begin
    case (req_op)
      CMD_LOAD: cnt_val = CNT_W'(req_dim_x) * CNT_W'(req_dim_y);
      CMD_SEND: cnt_val = CNT_W'(req_dim_x);
      default:  cnt_val = CLR_LEN;
    endcase
  end

  // Next-state, request latching and counter control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    buf_d    = buf_q;
    dim_x_d  = dim_x_q;
    dim_y_d  = dim_y_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          buf_d    = req_buf;
          dim_x_d  = req_dim_x;
          dim_y_d  = req_dim_y;
          cnt_load = req_ok;
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            case (req_op)
              CMD_LOAD: state_d = ST_LOAD_CMD;
              CMD_SEND: state_d = ST_SEND_CMD;
              default:  state_d = ST_CLEAR;
            endcase
          end
        end
      end
      ST_LOAD_CMD:  state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        cnt_en = in_valid;
        if (in_valid && cnt_last) state_d = ST_DONE;
      end
      ST_SEND_CMD:  state_d = ST_SEND_WAIT;
      ST_SEND_WAIT: state_d = ST_SEND_DATA;
      ST_SEND_DATA: begin
        cnt_en = out_ready;
        if (out_ready && cnt_last) state_d = ST_DONE;
      end
      ST_CLEAR: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= CMD_NONE;
      buf_q   <= '0;
      dim_x_q <= '0;
      dim_y_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      buf_q   <= buf_d;
      dim_x_q <= dim_x_d;
      dim_y_q <= dim_y_d;
      err_q   <= err_d;
    end
  end

  beat_counter #(.W(CNT_W)) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  // State-decoded outputs; a_out passes in_data straight through while loading.
  always_comb begin
    cmd       = CMD_NONE;
    stop      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    a_out     = '0;
    done      = 1'b0;
    case (state_q)
      ST_LOAD_CMD:  cmd = CMD_LOAD;
      ST_LOAD_DATA: begin
        in_ready = 1'b1;
        a_out    = in_data;
        stop     = !in_valid;
      end
      ST_SEND_CMD:  cmd = CMD_SEND;
      ST_SEND_DATA: begin
        out_valid = 1'b1;
        stop      = !out_ready;
      end
      ST_CLEAR:     cmd = CMD_CLEAR;
      ST_DONE:      done = 1'b1;
      default:      ;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = !req_ready;
  assign buffer    = buf_q;
  assign dim_x     = dim_x_q;
  assign dim_y     = dim_y_q;
  assign err       = err_q;

endmodule

// File: doc/buffer_ctrl.md
BUFFER_CTRL -- requirements
Module: buffer_ctrl

Interface
REQ-001 Parameter VAR_SIZE, default 8: element width, bits.
REQ-002 Parameter MMU_SIZE, default 10: max matrix dimension; CLEAR hold length.
REQ-003 Parameter BUF_NUM, default 10: number of addressable buffers (index 0..BUF_NUM-1).
REQ-004 Parameter DIM_W, default 5: width of dimension fields.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 Ports (name dir width meaning): clk in 1 clock; rst in 1 async active-high reset.
REQ-007 req_valid in 1, req_ready out 1, req_op in 2 (buffer cmd encoding), req_buf in 5, req_dim_x in DIM_W, req_dim_y in DIM_W: request channel.
REQ-008 in_valid in 1, in_ready out 1, in_data in VAR_SIZE: element stream for LOAD.
REQ-009 a_out out VAR_SIZE, cmd out 2, buffer out 5, dim_x out DIM_W, dim_y out DIM_W, stop out 1: drive to buffer_a.
REQ-010 out_valid out 1, out_ready in 1: qualify/stall buffer_a column output (B1) during SEND.
REQ-011 busy out 1, done out 1, err out 1: status.

Function
REQ-012 States: IDLE, LOAD_CMD, LOAD_DATA, SEND_CMD, SEND_WAIT, SEND_DATA, CLEAR, DONE.
REQ-013 req_ready SHALL be 1 only in IDLE; busy SHALL be !req_ready.
REQ-014 On req_valid&&req_ready, op/buf/dim_x/dim_y SHALL be latched; dim_x/dim_y outputs hold latched values until next accept.
REQ-015 Request invalid if op=NONE, req_buf>=BUF_NUM, or either dim is 0 or >MMU_SIZE: err pulses 1 cycle next cycle, no cmd issued, stay IDLE.
REQ-016 LOAD: cycle after accept, cmd=LOAD with buffer=id for exactly 1 cycle (LOAD_CMD), then LOAD_DATA.
REQ-017 LOAD_DATA: in_ready=1; a_out=in_data combinationally; stop=!in_valid; beat counted on in_valid; after dim_x*dim_y beats (column-major order, caller's duty) go to DONE.
REQ-018 SEND: cmd=SEND 1 cycle (SEND_CMD), 1 cycle SEND_WAIT (buffer latency), then SEND_DATA.
REQ-019 SEND_DATA: out_valid=1; stop=!out_ready; column counted on out_ready; after dim_x columns go to DONE.
REQ-020 CLEAR: cmd=CLEAR, buffer=id held exactly MMU_SIZE cycles, then DONE.
REQ-021 DONE: done=1 for 1 cycle, cmd=NONE, return to IDLE; new request acceptable the cycle after.
REQ-022 Outside the states above cmd=NONE, stop=0, in_ready=0, out_valid=0.
REQ-023 Beat counter width SHALL hold MMU_SIZE*MMU_SIZE without wrap; last beat detected by equality, not overflow.

Reset
REQ-024 rst SHALL immediately force IDLE, cmd=NONE, buffer=0, dim_x=dim_y=0, a_out=0, stop=0, done=err=0, out_valid=in_ready=0, counters=0.
REQ-025 Reset mid-operation SHALL abandon it without done; buffer contents are not guaranteed.

Configuration
REQ-026 Macro BUFFER_CTRL_VALID_EN: when defined, per-buffer valid bits (reset 0) set on LOAD done, cleared on CLEAR done; SEND to an invalid buffer SHALL be rejected as in REQ-015. When undefined, no valid bits exist and SEND is never rejected for content.

Structure
REQ-027 Shared package buffer_pkg: CMD_NONE=2'b00, CMD_LOAD=2'b01, CMD_SEND=2'b10, CMD_CLEAR=2'b11, state enum type; buffer_a and bench import it.
REQ-028 One sub-module beat_counter (load, enable, terminal count, last flag) instanced once, shared by all phases.

Verification
REQ-029 LOAD buf 3, 5x5, in_valid continuous -> cmd=LOAD 1 cycle, 25 beats, done at cycle 27 after accept; SEND buf 3 readback equals loaded matrix.
REQ-030 LOAD with in_valid low 3 cycles mid-stream -> stop=1 those 3 cycles, done delayed 3 cycles, data intact.
REQ-031 SEND 5x5 with out_ready low 2 cycles -> stop=1 and column count held 2 cycles; 5 columns total.
REQ-032 CLEAR buf 3 -> cmd=CLEAR exactly 10 cycles; subsequent SEND returns all zeros (with VALID_EN: err pulse, no SEND cmd).
REQ-033 Requests buf=12, dim_x=0, dim_y=11 each -> err 1 cycle, cmd stays NONE.
REQ-034 rst asserted at beat 7 of a LOAD -> all outputs at reset values same cycle; no done; next request accepted after release.
